tpu_result_tx: RTL and testbench
================================

Name: tpu_result_tx

Overview:
- Return path from the MLP to the UART controller: snapshots MLP status and the 32-bit accumulator and serializes them as a byte frame over a valid/ready byte stream.
- Triggered by an explicit read request from the UART controller, or automatically when the MLP enters its done state.
- Sits between the MLP status outputs (state, cycle count, acc0) and the UART TX byte interface.

Parameters:
- HDR_BYTE, 8'hA5, first byte of every frame.
- DONE_STATE, 4'd6, MLP state encoding that means "inference complete".
- AUTO_SEND, 1, 1 = also trigger on entry into DONE_STATE; 0 = rd_req only.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- rd_req  in  1  single-cycle read-result request from the UART controller
- mlp_state_in  in  4  MLP state
- mlp_cycle_cnt_in  in  5  MLP cycle counter
- mlp_acc0_in  in  32  signed accumulator result
- tx_data  out  8  frame byte toward the UART TX
- tx_valid  out  1  tx_data is valid
- tx_ready  in  1  UART TX accepts the byte
- busy  out  1  a frame is in flight
- overrun  out  1  sticky: a trigger arrived while busy
- overrun_clr  in  1  clears overrun

Behaviour:
- Reset (async assert, sync deassert by the environment): FSM=IDLE; tx_data=0, tx_valid=0, busy=0, overrun=0; snapshot registers=0; prev_done=0.
- Trigger:
  - trig = rd_req | (AUTO_SEND & done_now & ~prev_done).
  - done_now = (mlp_state_in == DONE_STATE); prev_done is registered every cycle.
- Snapshot: on a trig accepted in IDLE, capture st={mlp_cycle_cnt_in[3:0], mlp_state_in} and acc=mlp_acc0_in in the same edge. The frame reflects only these captured values; later input changes are ignored.
- Frame, in byte order: HDR_BYTE, st, acc[7:0], acc[15:8], acc[23:16], acc[31:24], with optional checksum (see Optional Feature). Accumulator is little-endian.
- FSM states: IDLE -> HDR -> STAT -> DATA (byte index 0..3, 2-bit counter) -> [CSUM] -> IDLE.
  - A state advances only on a handshake (tx_valid & tx_ready).
  - DATA advances its index per handshake and leaves DATA after index 3.
- Latency: trig accepted at edge N puts tx_valid=1 with tx_data=HDR_BYTE after edge N. With tx_ready held high, one byte transfers per cycle: 6 cycles per frame (7 with checksum). busy deasserts the cycle after the last handshake.
- Handshake rules:
  - tx_data and tx_valid are registered.
  - While tx_valid & ~tx_ready, tx_data is held stable and tx_valid stays 1.
  - tx_valid never drops without a handshake.
- Back-to-back frames: a trig in the same cycle as the final handshake is treated as busy (overrun). The next frame can start at the earliest one cycle after IDLE is re-entered.
- Busy trigger: a trig while busy is dropped, the snapshot is unchanged, and overrun is set to 1. overrun_clr clears it; if overrun_clr and a new overrun occur in the same cycle, set wins.
- An auto edge and rd_req in the same cycle produce one frame.
- Reset mid-frame: the frame is abandoned immediately and no further bytes are sent; the consumer must resynchronize on HDR_BYTE.
- AUTO_SEND=0: prev_done is still tracked, but only rd_req triggers.

Optional Feature:
- Macro: TPU_RESULT_CHECKSUM_EN.
- Defined: a CSUM state follows DATA and sends the XOR of all six preceding bytes. The XOR is accumulated as bytes handshake and is cleared on trig. Frame length is 7.
- Undefined: no CSUM state and no checksum register; frame length is 6, and DATA byte 3 returns to IDLE.

Decomposition:
- Shared package tpu_result_pkg holds:
  - the FSM state enum (IDLE, HDR, STAT, DATA, CSUM);
  - frame length constants (6 and 7);
  - default HDR_BYTE and DONE_STATE constants, so the UART controller decoder and the bench use identical values.
- No sub-module: the byte select is a small mux inside the FSM and does not justify its own module.

Test Plan:
- Reset, then acc0=32'h12345678, state=6, cycle_cnt=3, rd_req pulse, tx_ready=1 -> bytes A5 36 78 56 34 12 on consecutive cycles; busy=0 afterwards. With the checksum macro, a seventh byte 8'h9B follows.
- Same stimulus with tx_ready toggling 1,0,0,1,... -> identical byte sequence; tx_data stable while stalled; no duplicated or lost bytes.
- AUTO_SEND=1: state goes 5->6 and stays at 6 for 20 cycles -> exactly one frame. state 6->0->6 -> a second frame.
- rd_req again during frame byte 2, acc0 changed to 32'hFFFFFFFF -> frame continues with 78 56 34 12; overrun=1 until overrun_clr.
- rst_n asserted during DATA byte 1 -> tx_valid=0 and busy=0 asynchronously. After release, rd_req -> a fresh frame starting with A5.
- acc0=32'h80000000 (most negative) -> data bytes 00 00 00 80; sign is not altered.

Source files
------------

// File: rtl/tpu_result_pkg.sv
// Shared definitions for the MLP result return path: FSM states, frame
// lengths, and the header/done-state defaults used by the UART decoder too.
package tpu_result_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HDR  = 3'd1,
    STAT = 3'd2,
    DATA = 3'd3,
    CSUM = 3'd4
  } tx_state_e;

  localparam int FRAME_LEN_BASE = 6;
  localparam int FRAME_LEN_CSUM = 7;

  localparam logic [7:0] HDR_BYTE_DEF   = 8'hA5;
  localparam logic [3:0] DONE_STATE_DEF = 4'd6;

  // Little-endian byte lane of the accumulator snapshot
  function automatic logic [7:0] acc_byte(input logic [31:0] acc, input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = acc[7:0];
      2'd1:    b = acc[15:8];
      2'd2:    b = acc[23:16];
      2'd3:    b = acc[31:24];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  // Running XOR used for the optional frame checksum
  function automatic logic [7:0] xor_fold(input logic [7:0] sum, input logic [7:0] b);
    return sum ^ b;
  endfunction

endpackage

// File: rtl/tpu_result_tx.sv
// Snapshots MLP status/accumulator and serializes them as a byte frame.
// Define TPU_RESULT_CHECKSUM_EN to append an XOR checksum byte.
module tpu_result_tx
  import tpu_result_pkg::*;
#(
  parameter logic [7:0] HDR_BYTE   = HDR_BYTE_DEF,
  parameter logic [3:0] DONE_STATE = DONE_STATE_DEF,
  parameter bit         AUTO_SEND  = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rd_req,
  input  logic [3:0]  mlp_state_in,
  input  logic [4:0]  mlp_cycle_cnt_in,
  input  logic [31:0] mlp_acc0_in,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        busy,
  output logic        overrun,
  input  logic        overrun_clr
);

  tx_state_e   state_r;
  logic [1:0]  idx_r;
  logic [7:0]  st_r;
  logic [31:0] acc_r;
  logic        prev_done_r;

  logic done_now_s;
  logic trig_s;
  logic hs_s;
  logic accept_s;
  logic busy_trig_s;
  logic unused_cnt_msb_s;

  // Trigger qualification and handshake decode
  always_comb begin
    done_now_s  = (mlp_state_in == DONE_STATE);
    trig_s      = rd_req | (AUTO_SEND & done_now_s & ~prev_done_r);
    hs_s        = tx_valid & tx_ready;
    accept_s    = trig_s & (state_r == IDLE);
    busy_trig_s = trig_s & (state_r != IDLE);
  end

  assign unused_cnt_msb_s = mlp_cycle_cnt_in[4];

`ifdef TPU_RESULT_CHECKSUM_EN
  logic [7:0] csum_r;

  // Checksum accumulates every handshaken byte, restarted by each new frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      csum_r <= 8'h00;
    end else if (accept_s) begin
      csum_r <= 8'h00;
    end else if (hs_s) begin
      csum_r <= xor_fold(csum_r, tx_data);
    end else begin
      csum_r <= csum_r;
    end
  end
`endif

  // Sticky overrun flag; a new overrun in the same cycle beats the clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun <= 1'b0;
    end else if (busy_trig_s) begin
      overrun <= 1'b1;
    end else if (overrun_clr) begin
      overrun <= 1'b0;
    end else begin
      overrun <= overrun;
    end
  end

  // Frame FSM with registered byte stream outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      idx_r       <= 2'd0;
      st_r        <= 8'h00;
      acc_r       <= 32'h0000_0000;
      prev_done_r <= 1'b0;
      tx_data     <= 8'h00;
      tx_valid    <= 1'b0;
      busy        <= 1'b0;
    end else begin
      prev_done_r <= done_now_s;
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            st_r     <= {mlp_cycle_cnt_in[3:0], mlp_state_in};
            acc_r    <= mlp_acc0_in;
            tx_data  <= HDR_BYTE;
            tx_valid <= 1'b1;
            busy     <= 1'b1;
            idx_r    <= 2'd0;
            state_r  <= HDR;
          end
        end
        HDR: begin
          if (hs_s) begin
            tx_data <= st_r;
            state_r <= STAT;
          end
        end
        STAT: begin
          if (hs_s) begin
            idx_r   <= 2'd0;
            tx_data <= acc_byte(acc_r, 2'd0);
            state_r <= DATA;
          end
        end
        DATA: begin
          if (hs_s) begin
            if (idx_r == 2'd3) begin
`ifdef TPU_RESULT_CHECKSUM_EN
              // Last data byte is still on tx_data, fold it in directly
              tx_data <= xor_fold(csum_r, tx_data);
              state_r <= CSUM;
`else
              tx_valid <= 1'b0;
              busy     <= 1'b0;
              state_r  <= IDLE;
`endif
            end else begin
              idx_r   <= idx_r + 2'd1;
              tx_data <= acc_byte(acc_r, idx_r + 2'd1);
            end
          end
        end
        CSUM: begin
          if (hs_s) begin
            tx_valid <= 1'b0;
            busy     <= 1'b0;
            state_r  <= IDLE;
          end
        end
        default: begin
          tx_valid <= 1'b0;
          busy     <= 1'b0;
          state_r  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tpu_result_tx.sv
// Directed bench for tpu_result_tx: frame-level model plus literal frame checks.
module tb_tpu_result_tx;
  import tpu_result_pkg::*;

`ifdef TPU_RESULT_CHECKSUM_EN
  localparam int FL = FRAME_LEN_CSUM;
`else
  localparam int FL = FRAME_LEN_BASE;
`endif
  localparam bit AUTO = 1'b1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rd_req = 1'b0;
  logic [3:0]  mlp_state_in = 4'd0;
  logic [4:0]  mlp_cycle_cnt_in = 5'd0;
  logic [31:0] mlp_acc0_in = 32'h0;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b1;
  logic        busy;
  logic        overrun;
  logic        overrun_clr = 1'b0;

  tpu_result_tx #(.HDR_BYTE(HDR_BYTE_DEF), .DONE_STATE(DONE_STATE_DEF), .AUTO_SEND(AUTO)) dut (
    .clk(clk), .rst_n(rst_n), .rd_req(rd_req),
    .mlp_state_in(mlp_state_in), .mlp_cycle_cnt_in(mlp_cycle_cnt_in), .mlp_acc0_in(mlp_acc0_in),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .busy(busy), .overrun(overrun), .overrun_clr(overrun_clr)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q[$];
  logic [7:0] sent_q[$];
  bit         m_prev_done = 1'b0;
  bit         m_ovr = 1'b0;
  bit         m_busy, m_done, m_trig;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected frame built straight from the frame definition
  task automatic push_frame(input logic [3:0] s, input logic [4:0] c, input logic [31:0] a);
    logic [7:0] f[7];
    logic [7:0] x;
    f[0] = HDR_BYTE_DEF;
    f[1] = {c[3:0], s};
    for (int i = 0; i < 4; i++) f[2+i] = 8'((a >> (8*i)) & 32'hFF);
    x = 8'h00;
    for (int i = 0; i < 6; i++) x = x ^ f[i];
    f[6] = x;
    for (int i = 0; i < FL; i++) exp_q.push_back(f[i]);
  endtask

  // Per-cycle model comparison, sampled mid-cycle
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      m_prev_done = 1'b0;
      m_ovr = 1'b0;
    end else begin
      m_busy = (exp_q.size() > 0);
      chk("tx_valid", tx_valid, m_busy);
      chk("busy", busy, m_busy);
      chk("overrun", overrun, m_ovr);
      if (tx_valid && exp_q.size() > 0) chk("tx_data", tx_data, exp_q[0]);
      if (tx_valid && tx_ready && exp_q.size() > 0) begin
        sent_q.push_back(tx_data);
        void'(exp_q.pop_front());
      end
      m_done = (mlp_state_in == DONE_STATE_DEF);
      m_trig = rd_req | (AUTO & m_done & ~m_prev_done);
      m_prev_done = m_done;
      if (m_trig) begin
        if (m_busy) m_ovr = 1'b1;
        else push_frame(mlp_state_in, mlp_cycle_cnt_in, mlp_acc0_in);
      end else if (overrun_clr) begin
        m_ovr = 1'b0;
      end
    end
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_log(input string name, input logic [7:0] b0, input logic [7:0] b1,
                           input logic [7:0] b2, input logic [7:0] b3, input logic [7:0] b4,
                           input logic [7:0] b5, input logic [7:0] cs);
    logic [7:0] e[7];
    e[0] = b0; e[1] = b1; e[2] = b2; e[3] = b3; e[4] = b4; e[5] = b5; e[6] = cs;
    chk({name, "_len"}, sent_q.size(), FL);
    for (int i = 0; i < FL && i < sent_q.size(); i++)
      chk($sformatf("%s_b%0d", name, i), sent_q[i], e[i]);
    sent_q.delete();
  endtask

  task automatic pulse_rd;
    rd_req = 1'b1;
    tick(1);
    rd_req = 1'b0;
  endtask

  initial begin
    tick(3);
    chk("rst_tx_data", tx_data, 8'h00);
    chk("rst_tx_valid", tx_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_overrun", overrun, 1'b0);
    rst_n = 1'b1;
    tick(2);

    // Basic frame; rd_req coincides with the auto edge into DONE_STATE
    mlp_state_in = 4'd6; mlp_cycle_cnt_in = 5'd3; mlp_acc0_in = 32'h1234_5678;
    pulse_rd();
    chk("hdr_latency", {tx_valid, tx_data}, {1'b1, 8'hA5});
    tick(10);
    chk("idle_busy", busy, 1'b0);
    check_log("basic", 8'hA5, 8'h36, 8'h78, 8'h56, 8'h34, 8'h12, 8'h9B);

    // Stalling consumer
    pulse_rd();
    for (int i = 0; i < 24; i++) begin
      tx_ready = (i % 4 == 0 || i % 4 == 3);
      tick(1);
    end
    tx_ready = 1'b1;
    tick(4);
    check_log("stall", 8'hA5, 8'h36, 8'h78, 8'h56, 8'h34, 8'h12, 8'h9B);

    // Busy trigger with changed inputs, then clear collides with a new overrun
    pulse_rd();
    tick(2);
    mlp_acc0_in = 32'hFFFF_FFFF;
    pulse_rd();
    chk("ovr_set", overrun, 1'b1);
    rd_req = 1'b1; overrun_clr = 1'b1;
    tick(1);
    rd_req = 1'b0; overrun_clr = 1'b0;
    chk("ovr_set_wins", overrun, 1'b1);
    tick(6);
    chk("ovr_sticky", overrun, 1'b1);
    overrun_clr = 1'b1;
    tick(1);
    overrun_clr = 1'b0;
    chk("ovr_clr", overrun, 1'b0);
    check_log("ovr", 8'hA5, 8'h36, 8'h78, 8'h56, 8'h34, 8'h12, 8'h9B);

    // Auto trigger only on entry into DONE_STATE, most negative accumulator
    mlp_state_in = 4'd5; mlp_acc0_in = 32'h8000_0000;
    tick(2);
    mlp_state_in = 4'd6;
    tick(20);
    check_log("auto1", 8'hA5, 8'h36, 8'h00, 8'h00, 8'h00, 8'h80, 8'h13);
    mlp_state_in = 4'd0;
    tick(1);
    mlp_state_in = 4'd6;
    tick(12);
    check_log("auto2", 8'hA5, 8'h36, 8'h00, 8'h00, 8'h00, 8'h80, 8'h13);

    // Reset during DATA byte 1 abandons the frame
    mlp_acc0_in = 32'h1234_5678;
    pulse_rd();
    tick(3);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_valid", tx_valid, 1'b0);
    chk("midrst_busy", busy, 1'b0);
    mlp_state_in = 4'd2; mlp_cycle_cnt_in = 5'd9; mlp_acc0_in = 32'hCAFE_F00D;
    tick(2);
    rst_n = 1'b1;
    sent_q.delete();
    tick(2);
    chk("post_rst_quiet", tx_valid, 1'b0);
    pulse_rd();
    chk("fresh_hdr", tx_data, 8'hA5);
    tick(10);
    check_log("fresh", 8'hA5, 8'h92, 8'h0D, 8'hF0, 8'hFE, 8'hCA, 8'hFE);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
